// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator stage.
// Optional feature macro: PRODUCT_ACC_SAT_EN (see acc_adder).
package product_accumulator_pkg;

   localparam int PROD_W    = 16;
   localparam int ACC_W_DEF = 24;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } acc_state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / frame-result-out handshake bundle for product_accumulator.
// Optional feature macro: PRODUCT_ACC_SAT_EN (no effect on this file).
interface product_accumulator_if
   import product_accumulator_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] prod;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  acc_out;
   logic [CNT_W-1:0]  out_count;
   logic              overflow;

   modport slave (
      input  in_valid, prod, in_last, out_ready,
      output in_ready, out_valid, acc_out, out_count, overflow
   );

   modport master (
      output in_valid, prod, in_last, out_ready,
      input  in_ready, out_valid, acc_out, out_count, overflow
   );
endinterface

// File: rtl/product_accumulator_acc_adder.sv
// Combinational accumulator adder with carry-out.
// With PRODUCT_ACC_SAT_EN defined the sum clamps to all-ones on carry, else it wraps.
module acc_adder
   import product_accumulator_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0]  i_acc,
   input  logic [PROD_W-1:0] i_prod,
   output logic [ACC_W-1:0]  o_sum,
   output logic              o_carry
);
   logic [ACC_W:0] w_full;

   assign w_full  = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_prod};
   assign o_carry = w_full[ACC_W];

`ifdef PRODUCT_ACC_SAT_EN
   // A clamped accumulator keeps clamping: any further nonzero product carries again.
   assign o_sum = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
   assign o_sum = w_full[ACC_W-1:0];
`endif
endmodule

// File: rtl/product_accumulator.sv
// Frame-based accumulator of 16-bit products with valid/ready in and out.
// Optional feature macro: PRODUCT_ACC_SAT_EN selects saturating accumulation.
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   product_accumulator_if.slave  bus
);
   localparam logic [0:0] S_ACCUM = 1'(ST_ACCUM);
   localparam logic [0:0] S_HOLD  = 1'(ST_HOLD);

   logic [0:0]       r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;
   logic [ACC_W-1:0] r_acc_out;
   logic [CNT_W-1:0] r_out_count;
   logic             r_out_ovf;

   logic [ACC_W-1:0] w_sum;
   logic             w_carry;
   logic             w_accept;
   logic [CNT_W-1:0] w_cnt_next;

   acc_adder #(.ACC_W(ACC_W)) u_adder (
      .i_acc   (r_acc),
      .i_prod  (bus.prod),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   assign w_accept   = bus.in_valid & r_in_ready;
   assign w_cnt_next = (&r_count) ? r_count : r_count + {{(CNT_W-1){1'b0}}, 1'b1};

   // Frame FSM: accumulate beats, then hold the registered result until taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_ACCUM;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_acc       <= {ACC_W{1'b0}};
         r_count     <= {CNT_W{1'b0}};
         r_ovf       <= 1'b0;
         r_acc_out   <= {ACC_W{1'b0}};
         r_out_count <= {CNT_W{1'b0}};
         r_out_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_ACCUM: begin
               if (w_accept) begin
                  r_acc   <= w_sum;
                  r_count <= w_cnt_next;
                  r_ovf   <= r_ovf | w_carry;
                  if (bus.in_last) begin
                     r_acc_out   <= w_sum;
                     r_out_count <= w_cnt_next;
                     r_out_ovf   <= r_ovf | w_carry;
                     r_state     <= S_HOLD;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (bus.out_ready) begin
                  r_state     <= S_ACCUM;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_acc       <= {ACC_W{1'b0}};
                  r_count     <= {CNT_W{1'b0}};
                  r_ovf       <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_ACCUM;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_acc       <= {ACC_W{1'b0}};
               r_count     <= {CNT_W{1'b0}};
               r_ovf       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.acc_out   = r_acc_out;
   assign bus.out_count = r_out_count;
   assign bus.overflow  = r_out_ovf;
endmodule

// File: tb/tb_product_accumulator.sv
// Randomized self-checking bench for product_accumulator (ACC_W=16, CNT_W=4).
// Honors PRODUCT_ACC_SAT_EN in its reference model.
module tb_product_accumulator;
   import product_accumulator_pkg::*;

   localparam int TB_ACC_W = 16;
   localparam int TB_CNT_W = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   logic [15:0] q_beats[$];
   logic [31:0] e_acc;
   logic [31:0] e_cnt;
   logic [31:0] e_ovf;

   product_accumulator_if #(.ACC_W(TB_ACC_W), .CNT_W(TB_CNT_W)) bus ();

   product_accumulator #(.ACC_W(TB_ACC_W), .CNT_W(TB_CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: exact arithmetic sum of the frame, then apply wrap/clamp rules.
   task automatic model_frame();
      longint sum;
      longint maxv;
      sum  = 0;
      maxv = (64'd1 << TB_ACC_W) - 1;
      foreach (q_beats[i]) sum += longint'(q_beats[i]);
      e_ovf = (sum > maxv) ? 32'd1 : 32'd0;
`ifdef PRODUCT_ACC_SAT_EN
      e_acc = (sum > maxv) ? 32'(maxv) : 32'(sum);
`else
      e_acc = 32'(sum % (maxv + 1));
`endif
      e_cnt = (q_beats.size() > 15) ? 32'd15 : 32'(q_beats.size());
   endtask

   task automatic run_frame(input int hold_cycles, input logic idle_valid);
      model_frame();
      foreach (q_beats[i]) begin
         @(negedge clk);
         chk("in_ready_accum", 32'(bus.in_ready), 32'd1);
         bus.in_valid = 1'b1;
         bus.prod     = q_beats[i];
         bus.in_last  = (i == q_beats.size() - 1);
      end
      @(negedge clk);
      bus.in_valid = idle_valid;
      bus.in_last  = 1'b0;
      bus.prod     = 16'($urandom);
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("in_ready_hold", 32'(bus.in_ready), 32'd0);
      chk("acc_out", 32'(bus.acc_out), e_acc);
      chk("out_count", 32'(bus.out_count), e_cnt);
      chk("overflow", 32'(bus.overflow), e_ovf);
      for (int h = 0; h < hold_cycles; h++) begin
         bus.out_ready = 1'b0;
         @(negedge clk);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_acc_stable", 32'(bus.acc_out), e_acc);
         chk("bp_cnt_stable", 32'(bus.out_count), e_cnt);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk("ret_out_valid", 32'(bus.out_valid), 32'd0);
      chk("ret_in_ready", 32'(bus.in_ready), 32'd1);
      chk("ret_acc_retain", 32'(bus.acc_out), e_acc);
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.prod      = 16'd0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_acc_out", 32'(bus.acc_out), 32'd0);
      chk("rst_out_count", 32'(bus.out_count), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      rst = 1'b0;

      q_beats = '{16'd100, 16'd200, 16'd300};
      run_frame(0, 1'b0);
      chk("basic_600", 32'(bus.acc_out), 32'd600);

      q_beats = '{16'hFE01};
      run_frame(0, 1'b0);

      q_beats = '{16'd5, 16'd6};
      run_frame(5, 1'b1);
      q_beats = '{16'd1, 16'd2};
      run_frame(0, 1'b0);
      chk("after_bp_3", 32'(bus.acc_out), 32'd3);

      q_beats = '{16'hFFFF, 16'h0002};
      run_frame(1, 1'b0);
`ifdef PRODUCT_ACC_SAT_EN
      chk("ovf_sat_acc", 32'(bus.acc_out), 32'h0000FFFF);
`else
      chk("ovf_wrap_acc", 32'(bus.acc_out), 32'h00000001);
`endif
      chk("ovf_flag", 32'(bus.overflow), 32'd1);
      q_beats = '{16'd9};
      run_frame(0, 1'b0);
      chk("ovf_cleared", 32'(bus.overflow), 32'd0);

      q_beats.delete();
      for (int i = 0; i < 18; i++) q_beats.push_back(16'd1);
      run_frame(0, 1'b0);
      chk("cnt_saturate", 32'(bus.out_count), 32'd15);

      q_beats = '{16'hFFFF, 16'h8000, 16'h0000, 16'h0001};
      run_frame(0, 1'b0);

      // Mid-frame asynchronous reset between clock edges.
      q_beats = '{16'd50, 16'd60};
      foreach (q_beats[i]) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.prod     = q_beats[i];
         bus.in_last  = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_acc_out", 32'(bus.acc_out), 32'd0);
      chk("arst_out_count", 32'(bus.out_count), 32'd0);
      chk("arst_overflow", 32'(bus.overflow), 32'd0);
      rst = 1'b0;
      q_beats = '{16'd7};
      run_frame(0, 1'b0);
      chk("arst_next_acc", 32'(bus.acc_out), 32'd7);
      chk("arst_next_cnt", 32'(bus.out_count), 32'd1);

      for (int f = 0; f < 30; f++) begin
         int len;
         len = int'($urandom_range(1, 20));
         q_beats.delete();
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) q_beats.push_back(16'hFFFF);
            else q_beats.push_back(16'($urandom));
         end
         run_frame(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
